digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
- Upstream sequencer for the team's 2-to-4 decoder. It generates the 2-bit select pair (sel_hi -> decoder i1, sel_lo -> decoder i2) plus a decoder-enable for time-multiplexed scanning of 4 digit/row lines.
- Supports two modes:
  - Auto scan, with a programmable dwell time.
  - Manual stepping.
- Also provides per-digit skip masking, blanking dead-time between digits, and an end-of-frame pulse.

Parameters:
- PRESCALE, 4, clock cycles each digit stays enabled in auto mode (>=1).
- BLANK_CYCLES, 1, cycles dec_en is held low between digits (>=0; 0 means no blank).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- mode  in  1  0 = auto scan, 1 = manual step.
- step  in  1  manual advance; each cycle sampled high in ACTIVE counts as one request.
- digit_mask  in  4  bit k = 1 means digit k is scanned; bit k = 0 means it is skipped.
- sel_hi  out  1  select MSB; drives decoder i1.
- sel_lo  out  1  select LSB; drives decoder i2.
- dec_en  out  1  high while the selected digit may be driven.
- frame_done  out  1  single-cycle pulse when the select wraps.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n = 0):
  - State IDLE; sel = 00; dec_en = 0; frame_done = 0; dwell and blank counters = 0.
  - Reset mid-scan aborts immediately, with no blank phase.
- Select encoding: index = {sel_hi, sel_lo}. Index 0..3 maps to decoder outputs o1..o4.
- Next-digit search:
  - Search the lowest set mask bit strictly above the current index.
  - If none, wrap and search from index 0 upward (this includes the current index).
  - A wrap occurs when the next index <= the current index.
- States are IDLE, ACTIVE and BLANK.
- IDLE:
  - dec_en = 0; sel holds its value.
  - If en = 1 and digit_mask != 0: sel <= lowest set mask index, dec_en <= 1, go to ACTIVE.
  - frame_done is not pulsed on entry.
- ACTIVE:
  - dec_en = 1; the dwell counter runs.
  - Auto mode: after exactly PRESCALE cycles with dec_en high, leave ACTIVE.
  - Manual mode: leave ACTIVE in the cycle after step is sampled high; the dwell counter is ignored.
  - Leaving ACTIVE when BLANK_CYCLES > 0: go to BLANK; dec_en <= 0; sel holds.
  - Leaving ACTIVE when BLANK_CYCLES = 0: sel <= next digit directly, and ACTIVE restarts with the dwell counter cleared.
  - If the mask bit of the current index drops to 0, leave ACTIVE in the next cycle, as if the dwell had expired.
- BLANK:
  - dec_en = 0 for exactly BLANK_CYCLES cycles.
  - Then sel <= next digit, dec_en <= 1, go to ACTIVE.
  - sel and dec_en update in the same cycle, so the decoder never sees a select change while enabled.
- frame_done: pulses high for 1 cycle, aligned with the cycle in which sel takes a wrapped value.
- Single enabled digit: the search wraps to itself. The blank phase is still inserted, and frame_done pulses on every re-entry.
- en = 0 in any state: go to IDLE next cycle; dec_en <= 0; sel holds; counters clear. There is no blank phase and no frame_done.
- digit_mask = 0 in ACTIVE or BLANK: go to IDLE next cycle; same effects as en = 0.
- Mode changes:
  - A change takes effect at the next ACTIVE-exit evaluation.
  - On a switch to auto mode, the dwell counter restarts at 0.
  - step is ignored outside ACTIVE and in auto mode.
- The mask is sampled at the cycle the next digit is computed. Changes do not retroactively affect the current digit, except a dropped current bit as stated above.

Test Plan:
- Reset and start:
  - rst_n = 0 -> sel = 00, dec_en = 0, frame_done = 0.
  - Release rst_n with en = 0 -> outputs remain unchanged.
- Auto scan, PRESCALE = 4, BLANK_CYCLES = 1, mask = 1111, en = 1:
  - Required pattern per digit: dec_en high for 4 cycles, then low for 1.
  - sel sequence 00, 01, 10, 11, 00.
  - frame_done pulses exactly once, in the cycle sel returns to 00.
  - The decoder outputs o1..o4 assert one-hot in turn and never overlap.
- Skip mask = 0101:
  - sel sequence 00, 10, 00, 10.
  - frame_done pulses on each 10 -> 00 transition.
  - Mask = 1000: sel stays 11, dec_en toggles 4 high / 1 low, frame_done pulses every 5 cycles.
- Manual mode, mode = 1, BLANK_CYCLES = 0:
  - With no step, the digit holds for 50 cycles with dec_en = 1.
  - Three single-cycle step pulses move sel 00 -> 01 -> 10 -> 11.
  - step held high for 4 cycles advances 4 digits and pulses frame_done once.
- Abort paths:
  - en dropped in the 2nd dwell cycle of digit 01 -> next cycle dec_en = 0, sel = 01, state IDLE.
  - Re-raising en restarts at the lowest enabled digit.
  - digit_mask set to 0 mid-BLANK -> IDLE.
- Asynchronous reset mid-ACTIVE: assert rst_n low between clock edges -> dec_en and sel clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/digit_scan_ctrl_if.sv
// Control/status bundle between a scan-controller client and digit_scan_ctrl.
// The master drives the scan controls; the slave (the controller) drives the decoder-side outputs.
interface digit_scan_ctrl_if;
    logic       en;
    logic       mode;
    logic       step;
    logic [3:0] digit_mask;
    logic       sel_hi;
    logic       sel_lo;
    logic       dec_en;
    logic       frame_done;

    modport master (
        output en, mode, step, digit_mask,
        input  sel_hi, sel_lo, dec_en, frame_done
    );

    modport slave (
        input  en, mode, step, digit_mask,
        output sel_hi, sel_lo, dec_en, frame_done
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Scan sequencer for the 2-to-4 digit decoder: walks the enabled digits with a
// dwell time (auto) or on step requests (manual), with blanking between digits.
module digit_scan_ctrl #(
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    digit_scan_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;

    localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic [1:0]    state,     state_d;
    logic [1:0]    sel,       sel_d;
    logic          dec_en_q,  dec_en_d;
    logic          frame_q,   frame_d;
    logic [DW-1:0] dwell_cnt, dwell_d;
    logic [BW-1:0] blank_cnt, blank_d;

    logic [1:0] next_idx;
    logic       abort;
    logic       leave;
    logic       advance;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Lowest enabled digit strictly above cur; otherwise wrap to the lowest enabled overall.
    function automatic logic [1:0] next_digit(input logic [1:0] cur, input logic [3:0] m);
        logic [3:0] above;
        above = m & (4'b1110 << cur);
        return (above != 4'b0000) ? lowest_set(above) : lowest_set(m);
    endfunction

    assign next_idx = next_digit(sel, bus.digit_mask);
    assign abort    = !bus.en || (bus.digit_mask == 4'b0000);

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        sel_d    = sel;
        dec_en_d = 1'b0;
        frame_d  = 1'b0;
        dwell_d  = '0;
        blank_d  = '0;
        leave    = 1'b0;
        advance  = 1'b0;

        case (state)
            S_IDLE: begin
                if (!abort) begin
                    state_d  = S_ACTIVE;
                    sel_d    = lowest_set(bus.digit_mask);
                    dec_en_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // A dropped mask bit for the shown digit ends the dwell early.
                    leave = (bus.mode ? bus.step : (dwell_cnt == DWELL_LAST))
                            || !bus.digit_mask[sel];
                    if (!leave) begin
                        dec_en_d = 1'b1;
                        dwell_d  = bus.mode ? '0 : dwell_cnt + 1'b1;
                    end else if (BLANK_CYCLES > 0) begin
                        state_d = S_BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (blank_cnt == BLANK_LAST) begin
                    advance = 1'b1;
                end else begin
                    blank_d = blank_cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Select and enable change on the same edge, so the decoder never sees a select change while enabled.
        if (advance) begin
            state_d  = S_ACTIVE;
            sel_d    = next_idx;
            dec_en_d = 1'b1;
            frame_d  = (next_idx <= sel);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel       <= 2'b00;
            dec_en_q  <= 1'b0;
            frame_q   <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            dec_en_q  <= dec_en_d;
            frame_q   <= frame_d;
            dwell_cnt <= dwell_d;
            blank_cnt <= blank_d;
        end
    end

    assign bus.sel_hi     = sel[1];
    assign bus.sel_lo     = sel[0];
    assign bus.dec_en     = dec_en_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: two instances (with and without blanking) share stimulus
// and are compared every cycle against a behavioural scan model, plus directed checks.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_r = 1'b0;
    logic       mode_r = 1'b0;
    logic       step_r = 1'b0;
    logic [3:0] mask_r = 4'b0000;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl_if if_a ();
    digit_scan_ctrl_if if_b ();

    assign if_a.en = en_r;   assign if_a.mode = mode_r;
    assign if_a.step = step_r; assign if_a.digit_mask = mask_r;
    assign if_b.en = en_r;   assign if_b.mode = mode_r;
    assign if_b.step = step_r; assign if_b.digit_mask = mask_r;

    digit_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    digit_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    // Behavioural view: running or not, showing a digit or blanking, cycles spent in the current phase.
    typedef struct {
        bit run;
        bit blanking;
        int digit;
        int ticks;
        bit fd;
    } model_t;

    model_t ma, mb;

    function automatic int first_enabled(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int search_after(input int cur, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    function automatic model_t advance(input model_t m, input bit en, input bit mode, input bit step,
                                       input logic [3:0] mask, input int prescale, input int blank);
        model_t n;
        bit go_next;
        n = m;
        n.fd = 0;
        go_next = 0;
        if (!m.run) begin
            if (en && mask != 0) begin
                n.run = 1; n.blanking = 0; n.ticks = 0; n.digit = first_enabled(mask);
            end
            return n;
        end
        if (!en || mask == 0) begin
            n.run = 0; n.blanking = 0; n.ticks = 0;
            return n;
        end
        if (!m.blanking) begin
            if ((mode ? step : (m.ticks + 1 >= prescale)) || !mask[m.digit]) begin
                if (blank > 0) begin
                    n.blanking = 1; n.ticks = 0;
                end else begin
                    go_next = 1;
                end
            end else begin
                n.ticks = mode ? 0 : m.ticks + 1;
            end
        end else begin
            if (m.ticks + 1 < blank) n.ticks = m.ticks + 1;
            else go_next = 1;
        end
        if (go_next) begin
            n.digit = search_after(m.digit, mask);
            n.fd = (n.digit <= m.digit);
            n.blanking = 0;
            n.ticks = 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a_sel",    {30'd0, if_a.sel_hi, if_a.sel_lo}, 32'(ma.digit));
        check("a_dec_en", {31'd0, if_a.dec_en},              {31'd0, ma.run && !ma.blanking});
        check("a_frame",  {31'd0, if_a.frame_done},          {31'd0, ma.fd});
        check("b_sel",    {30'd0, if_b.sel_hi, if_b.sel_lo}, 32'(mb.digit));
        check("b_dec_en", {31'd0, if_b.dec_en},              {31'd0, mb.run && !mb.blanking});
        check("b_frame",  {31'd0, if_b.frame_done},          {31'd0, mb.fd});
    endtask

    task automatic tick();
        @(posedge clk);
        ma = advance(ma, en_r, mode_r, step_r, mask_r, 4, 1);
        mb = advance(mb, en_r, mode_r, step_r, mask_r, 4, 0);
        #1;
        compare_all();
    endtask

    function automatic logic [1:0] sel_a();
        return {if_a.sel_hi, if_a.sel_lo};
    endfunction

    function automatic logic [1:0] sel_b();
        return {if_b.sel_hi, if_b.sel_lo};
    endfunction

    initial begin
        int fd_cnt, hi_cnt, hold_cnt;
        logic prev_en;
        logic [1:0] entries[$];
        logic [1:0] exp_seq1[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_seq2[4] = '{2'd2, 2'd0, 2'd2, 2'd0};

        ma = '{default: 0};
        mb = '{default: 0};

        // Reset state
        #3;
        check("rst_sel",    {30'd0, sel_a()}, 32'd0);
        check("rst_dec_en", {31'd0, if_a.dec_en}, 32'd0);
        check("rst_frame",  {31'd0, if_a.frame_done}, 32'd0);
        check("rst_b_dec",  {31'd0, if_b.dec_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Auto scan, full mask
        en_r = 1'b1; mask_r = 4'b1111; mode_r = 1'b0;
        prev_en = 1'b0; fd_cnt = 0; hi_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (if_a.dec_en && !prev_en) entries.push_back(sel_a());
            prev_en = if_a.dec_en;
            fd_cnt += int'(if_a.frame_done);
            hi_cnt += int'(if_a.dec_en);
        end
        check("auto_entries", 32'(entries.size()), 32'd5);
        for (int i = 0; i < 5 && i < entries.size(); i++) check("auto_seq", {30'd0, entries[i]}, {30'd0, exp_seq1[i]});
        check("auto_frames", 32'(fd_cnt), 32'd1);
        check("auto_dec_hi", 32'(hi_cnt), 32'd17);

        // Skip mask 0101
        mask_r = 4'b0101;
        entries.delete(); fd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_a.dec_en && !prev_en) entries.push_back(sel_a());
            prev_en = if_a.dec_en;
            fd_cnt += int'(if_a.frame_done);
        end
        check("skip_entries", 32'(entries.size()), 32'd4);
        for (int i = 0; i < 4 && i < entries.size(); i++) check("skip_seq", {30'd0, entries[i]}, {30'd0, exp_seq2[i]});
        check("skip_frames", 32'(fd_cnt), 32'd2);

        // Single digit 3
        mask_r = 4'b1000;
        for (int i = 0; i < 3; i++) tick();
        fd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            fd_cnt += int'(if_a.frame_done);
        end
        check("single_frames", 32'(fd_cnt), 32'd4);
        check("single_sel", {30'd0, sel_a()}, 32'd3);

        // Manual stepping
        en_r = 1'b0;
        tick(); tick();
        en_r = 1'b1; mode_r = 1'b1; mask_r = 4'b1111;
        tick();
        hold_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if_b.dec_en && sel_b() == 2'd0) hold_cnt++;
        end
        check("man_hold", 32'(hold_cnt), 32'd50);
        for (int s = 1; s <= 3; s++) begin
            step_r = 1'b1; tick();
            step_r = 1'b0;
            check("man_step_sel", {30'd0, sel_b()}, 32'(s));
            tick(); tick();
        end
        fd_cnt = 0;
        step_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            fd_cnt += int'(if_b.frame_done);
        end
        step_r = 1'b0;
        check("man_burst_frames", 32'(fd_cnt), 32'd1);
        check("man_burst_sel", {30'd0, sel_b()}, 32'd3);

        // Abort by en in 2nd dwell cycle of digit 01
        mode_r = 1'b0; en_r = 1'b0;
        tick();
        en_r = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        en_r = 1'b0;
        tick();
        check("abort_sel",    {30'd0, sel_a()}, 32'd1);
        check("abort_dec_en", {31'd0, if_a.dec_en}, 32'd0);
        en_r = 1'b1;
        tick();
        check("restart_sel",    {30'd0, sel_a()}, 32'd0);
        check("restart_dec_en", {31'd0, if_a.dec_en}, 32'd1);

        // Mask cleared during blank
        for (int i = 0; i < 4; i++) tick();
        check("in_blank", {31'd0, if_a.dec_en}, 32'd0);
        mask_r = 4'b0000;
        tick();
        mask_r = 4'b1111;
        tick();
        check("mask0_restart_sel", {30'd0, sel_a()}, 32'd0);
        check("mask0_restart_en",  {31'd0, if_a.dec_en}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en_r   = ($urandom_range(0, 19) != 0);
            step_r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) mask_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
            tick();
        end

        // Asynchronous reset while showing digit 01
        en_r = 1'b0; mode_r = 1'b0; step_r = 1'b0;
        tick();
        en_r = 1'b1; mask_r = 4'b1111;
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_sel", {30'd0, sel_a()}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sel",   {30'd0, sel_a()}, 32'd0);
        check("async_rst_dec",   {31'd0, if_a.dec_en}, 32'd0);
        check("async_rst_b_dec", {31'd0, if_b.dec_en}, 32'd0);
        ma = '{default: 0};
        mb = '{default: 0};
        en_r = 1'b0;
        rst_n = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
